// File: rtl/mul_div_unit_if.sv
// Operand, control and result bundle between the control unit and mul_div_unit.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// 32-cycle shift-add multiply and restoring divide; sign handled on magnitudes.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete
// immediately (one-cycle done pulse) and leave HI/LO untouched.
module mul_div_unit (
    input  logic          clk,
    input  logic          clrn,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] ah;          // product high / partial remainder
    logic [31:0] al;          // multiplier bits / dividend bits -> quotient
    logic [31:0] md;          // multiplicand / divisor magnitude
    logic        neg_q;       // negate product or quotient
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [63:0] prod_fix;

`ifdef MDU_DIV_EN
    logic [1:0]  op_r;
    logic        neg_r;       // negate remainder (dividend was negative)
    logic        dz;          // divisor was zero
    logic [31:0] a_raw;       // raw dividend, returned in HI on divide-by-zero
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Operand magnitudes, single-iteration datapath steps and sign correction
    always_comb begin
        sgn      = ~bus.op[0];
        a_mag    = (sgn && bus.a[31]) ? -bus.a : bus.a;
        b_mag    = (sgn && bus.b[31]) ? -bus.b : bus.b;
        mul_sum  = {1'b0, ah} + (al[0] ? {1'b0, md} : 33'd0);
        prod     = {ah, al};
        prod_fix = neg_q ? -prod : prod;
`ifdef MDU_DIV_EN
        div_shift = {ah, al[31]};
        div_diff  = div_shift - {1'b0, md};
        quo_fix   = neg_q ? -al : al;
        rem_fix   = neg_r ? -ah : ah;
`endif
    end

    // Control FSM, iteration registers and HI/LO, all registered
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            ah     <= '0;
            al     <= '0;
            md     <= '0;
            neg_q  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef MDU_DIV_EN
            op_r   <= '0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            a_raw  <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt   <= '0;
                        ah    <= '0;
                        neg_q <= sgn & (bus.a[31] ^ bus.b[31]);
`ifdef MDU_DIV_EN
                        op_r   <= bus.op;
                        neg_r  <= sgn & bus.a[31];
                        dz     <= (bus.b == '0);
                        a_raw  <= bus.a;
                        state  <= RUN;
                        busy_r <= 1'b1;
                        if (bus.op[1]) begin
                            al <= a_mag;
                            md <= b_mag;
                        end else begin
                            al <= b_mag;
                            md <= a_mag;
                        end
`else
                        // Divides are acknowledged at once; loading the
                        // multiply registers for them is harmless.
                        al <= b_mag;
                        md <= a_mag;
                        if (bus.op[1]) begin
                            done_r <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
`endif
                    end else begin
                        if (bus.mthi) hi_r <= bus.a;
                        if (bus.mtlo) lo_r <= bus.a;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
`ifdef MDU_DIV_EN
                    if (op_r[1]) begin
                        if (!div_diff[32]) begin
                            ah <= div_diff[31:0];
                            al <= {al[30:0], 1'b1};
                        end else begin
                            ah <= div_shift[31:0];
                            al <= {al[30:0], 1'b0};
                        end
                    end else begin
                        ah <= mul_sum[32:1];
                        al <= {mul_sum[0], al[31:1]};
                    end
`else
                    ah <= mul_sum[32:1];
                    al <= {mul_sum[0], al[31:1]};
`endif
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
`ifdef MDU_DIV_EN
                    if (op_r[1]) begin
                        if (dz) begin
                            hi_r <= a_raw;
                            lo_r <= '1;
                        end else begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
`else
                    {hi_r, lo_r} <= prod_fix;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS-style integer datapath. It sits directly downstream of the register file: it takes the two read-port values (rs on `a`, rt on `b`), runs a 32-iteration shift-add multiply or restoring divide, and holds the result in architectural HI/LO registers. The control unit stalls on `busy` and reads HI/LO through `hi`/`lo` for `mfhi`/`mflo`.

## Interface
Parameters: none; width is fixed at 32.

- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- start  in  1  launch an operation; sampled only when `busy`=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (multiplicand or dividend).
- b  in  32  rt operand (multiplier or divisor).
- mthi  in  1  write `a` into HI when idle.
- mtlo  in  1  write `a` into LO when idle.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO were just updated by an operation.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE: `start`=1 latches `op`, the magnitudes of `a`/`b` (signed ops) or raw values (unsigned ops), and the result-sign flags; clears the 6-bit iteration counter; moves to RUN.
  - RUN: one iteration per cycle. After the 32nd iteration (counter = 31), moves to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
- MULT/MULTU: {HI,LO} = 64-bit product. Signed: magnitude product, negated if exactly one operand is negative.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divisor zero (both DIV and DIVU): LO = 32'hFFFFFFFF, HI = `a` as sampled at start. Normal latency, no exception.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- `mthi`/`mtlo` apply only in IDLE and only when `start`=0. `start` has priority, and the move is dropped. Both may be asserted together.
- `start`, `mthi`, `mtlo` while `busy`=1 are ignored. No queueing.
- `op`, `a`, `b` are don't-care after the start edge.

## Timing
- Start sampled at edge E0. RUN occupies edges E1..E32. The FIX update happens at edge E33.
- `busy` is high from after E0 until after E33 (33 cycles). It is registered and combinationally independent of `start`.
- `hi`/`lo` hold their old values until E33, then change exactly once, with no intermediate values visible.
- `done` is high for exactly the cycle between E33 and E34.
- A new `start` may be accepted at E34, during the `done` cycle.
- `mthi`/`mtlo` take effect at the same edge; `hi`/`lo` show the new value in the next cycle.
- Reset: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0. Values apply immediately on `clrn` falling.
- Reset during RUN/FIX aborts the operation; HI/LO read 0, not a partial result.

## Configuration
- `MDU_DIV_EN` defined: full behaviour above; the divider datapath is built.
- `MDU_DIV_EN` undefined: the divider is not synthesized.
  - DIV/DIVU are accepted, `busy` stays 0, and `done` pulses in the cycle after the start edge.
  - HI/LO are unchanged.
  - Multiply timing is identical in both configurations.

## Test plan
- Reset then MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF → `busy` high for 33 cycles; then HI=32'hFFFFFFFE, LO=32'h00000001 with a one-cycle `done`.
- MULT a=-7 (32'hFFFFFFF9), b=6 → HI=32'hFFFFFFFF, LO=32'hFFFFFFD6. Then DIV a=-7, b=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU a=100, b=0 → LO=32'hFFFFFFFF, HI=100. DIV a=32'h80000000, b=-1 → LO=32'h80000000, HI=0.
- `mthi` a=32'h1234 in IDLE → HI=32'h1234. `mtlo` plus `start` in the same cycle → start taken, LO not written. Second `start` and `mtlo` while busy → ignored; the result equals the first operation's.
- Start MULTU 3×5, pull `clrn` low at cycle 10 → `busy`, `done`, HI, LO all 0 immediately; no `done` after release.
- Build without `MDU_DIV_EN`: DIVU 10/3 → `done` the next cycle, `busy` never high, HI/LO unchanged. MULTU 3×5 → LO=15 at E33.
